// File: rtl/gsim_pkg.sv
// Shared definitions for the gsim host: FSM states, run status codes, vector
// length and the 7-tap stencil coefficients of the residual check.
package gsim_pkg;

  localparam int N       = 16;
  localparam int IDX_W   = 4;
  localparam int RESID_W = 38;

  localparam int signed COEF_0 = 20;
  localparam int signed COEF_1 = -13;
  localparam int signed COEF_2 = 6;
  localparam int signed COEF_3 = -1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
`ifdef GSIM_HOST_RESID_EN
    ST_CHECK,
`endif
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_SHORT   = 2'd2
  } err_e;

endpackage

// File: rtl/gsim_resid_row.sv
// Combinational residual of one stencil row: A*x at row i minus b_i in Q16.16,
// evaluated in 38-bit signed arithmetic. Out-of-range taps arrive as zero.
module gsim_resid_row
  import gsim_pkg::*;
(
  input  logic signed [31:0]        x_m3,
  input  logic signed [31:0]        x_m2,
  input  logic signed [31:0]        x_m1,
  input  logic signed [31:0]        x_c,
  input  logic signed [31:0]        x_p1,
  input  logic signed [31:0]        x_p2,
  input  logic signed [31:0]        x_p3,
  input  logic signed [15:0]        b_i,
  output logic signed [RESID_W-1:0] r_o
);

  localparam logic signed [RESID_W-1:0] C0 = RESID_W'(COEF_0);
  localparam logic signed [RESID_W-1:0] C1 = RESID_W'(COEF_1);
  localparam logic signed [RESID_W-1:0] C2 = RESID_W'(COEF_2);
  localparam logic signed [RESID_W-1:0] C3 = RESID_W'(COEF_3);

  logic signed [RESID_W-1:0] s0, s1, s2, s3, b_q16;

  always_comb begin
    s0    = RESID_W'(x_c);
    s1    = RESID_W'(x_m1) + RESID_W'(x_p1);
    s2    = RESID_W'(x_m2) + RESID_W'(x_p2);
    s3    = RESID_W'(x_m3) + RESID_W'(x_p3);
    // b is an integer; shift it into Q16.16 to match the x scale.
    b_q16 = RESID_W'(b_i) <<< 16;
    r_o   = C0 * s0 + C1 * s1 + C2 * s2 + C3 * s3 - b_q16;
  end

endmodule

// File: rtl/gsim_host.sv
// Host sequencer for the gsim solver: streams b out, collects a 16-word x burst
// with timeout/short-burst detection. GSIM_HOST_RESID_EN adds a residual check.
module gsim_host #(
  parameter int          N         = 16,
  parameter int          TIMEOUT   = 2048,
  parameter logic [37:0] RESID_TOL = 38'd64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               b_wr,
  input  logic [3:0]         b_wr_addr,
  input  logic signed [15:0] b_wr_data,
  input  logic               start,
  output logic               in_en,
  output logic signed [15:0] b_in,
  input  logic               out_valid,
  input  logic signed [31:0] x_out,
  input  logic [3:0]         x_rd_addr,
  output logic signed [31:0] x_rd_data,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err
`ifdef GSIM_HOST_RESID_EN
  ,
  output logic [37:0]        max_resid,
  output logic [0:0]         pass
`endif
);

  import gsim_pkg::*;

  localparam int                WAIT_W    = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         err_q, err_d;
  logic signed [15:0] b_buf_q [N];
  logic signed [15:0] b_buf_d [N];
  logic signed [31:0] x_buf_q [N];
  logic signed [31:0] x_buf_d [N];

`ifdef GSIM_HOST_RESID_EN
  logic [RESID_W-1:0]        max_resid_q, max_resid_d, resid_abs, resid_max_new;
  logic                      pass_q, pass_d;
  logic signed [RESID_W-1:0] resid_row;
  logic signed [31:0]        tap [7];
  int                        tap_idx;

  always_comb begin
    tap_idx = 0;
    for (int d = 0; d < 7; d++) begin
      tap_idx = int'(idx_q) + d - 3;
      tap[d]  = (tap_idx >= 0 && tap_idx < N) ? x_buf_q[tap_idx[IDX_W-1:0]] : '0;
    end
  end

  gsim_resid_row u_resid_row (
    .x_m3 (tap[0]),
    .x_m2 (tap[1]),
    .x_m1 (tap[2]),
    .x_c  (tap[3]),
    .x_p1 (tap[4]),
    .x_p2 (tap[5]),
    .x_p3 (tap[6]),
    .b_i  (b_buf_q[idx_q]),
    .r_o  (resid_row)
  );

  always_comb begin
    resid_abs     = resid_row[RESID_W-1] ? RESID_W'(-resid_row) : RESID_W'(resid_row);
    resid_max_new = (resid_abs > max_resid_q) ? resid_abs : max_resid_q;
    max_resid_d   = max_resid_q;
    pass_d        = pass_q;
    if (state_q == ST_IDLE && start) begin
      max_resid_d = '0;
      pass_d      = 1'b0;
    end else if (state_q == ST_CHECK) begin
      max_resid_d = resid_max_new;
      if (idx_q == IDX_LAST) pass_d = (resid_max_new <= RESID_TOL) && (err_q == ERR_OK);
    end
  end

  assign max_resid = max_resid_q;
  assign pass      = pass_q;
`endif

  // Next-state and datapath updates.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which is what keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    err_d   = err_q;
    b_buf_d = b_buf_q;
    x_buf_d = x_buf_q;
    if (b_wr) b_buf_d[b_wr_addr] = b_wr_data;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEND;
          idx_d   = '0;
          err_d   = ERR_OK;
        end
      end
      ST_SEND: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_WAIT;
          wait_d  = '0;
        end
      end
      ST_WAIT: begin
        if (out_valid) begin
          x_buf_d[0] = x_out;
          idx_d      = IDX_W'(1);
          state_d    = ST_RECV;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_RECV: begin
        if (out_valid) begin
          x_buf_d[idx_q] = x_out;
          idx_d          = idx_q + 1'b1;
`ifdef GSIM_HOST_RESID_EN
          if (idx_q == IDX_LAST) state_d = ST_CHECK;
`else
          if (idx_q == IDX_LAST) state_d = ST_DONE;
`endif
        end else begin
          err_d   = ERR_SHORT;
          state_d = ST_DONE;
        end
      end
`ifdef GSIM_HOST_RESID_EN
      ST_CHECK: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_en = 1'b0;
    b_in  = '0;
    busy  = (state_q != ST_IDLE);
    done  = (state_q == ST_DONE);
    if (state_q == ST_SEND) begin
      in_en = 1'b1;
      b_in  = b_buf_q[idx_q];
    end
  end

  assign err       = err_q;
  assign x_rd_data = x_buf_q[x_rd_addr];

  // NOTE: both buffers are reset explicitly because their all-zero reset
  // content is observable on x_rd_data and b_in, so they cannot be left as RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      err_q   <= ERR_OK;
      for (int i = 0; i < N; i++) begin
        b_buf_q[i] <= '0;
        x_buf_q[i] <= '0;
      end
`ifdef GSIM_HOST_RESID_EN
      max_resid_q <= '0;
      pass_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      b_buf_q <= b_buf_d;
      x_buf_q <= x_buf_d;
`ifdef GSIM_HOST_RESID_EN
      max_resid_q <= max_resid_d;
      pass_q      <= pass_d;
`endif
    end
  end

endmodule

// File: tb/tb_gsim_host.sv
// Self-checking bench for gsim_host: randomized runs against a behavioural model
// of the host (b/x buffers, run status, residual when GSIM_HOST_RESID_EN is set).
module tb_gsim_host;

  localparam int N       = 16;
  localparam int TIMEOUT = 2048;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               b_wr = 1'b0;
  logic [3:0]         b_wr_addr = '0;
  logic signed [15:0] b_wr_data = '0;
  logic               start = 1'b0;
  logic               out_valid = 1'b0;
  logic signed [31:0] x_out = '0;
  logic [3:0]         x_rd_addr = '0;
  logic               in_en, busy, done;
  logic signed [15:0] b_in;
  logic signed [31:0] x_rd_data;
  logic [1:0]         err;
`ifdef GSIM_HOST_RESID_EN
  logic [37:0]        max_resid;
  logic [0:0]         pass;
`endif

  gsim_host #(.N(N), .TIMEOUT(TIMEOUT), .RESID_TOL(38'd64)) dut (
    .clk       (clk),
    .reset     (reset),
    .b_wr      (b_wr),
    .b_wr_addr (b_wr_addr),
    .b_wr_data (b_wr_data),
    .start     (start),
    .in_en     (in_en),
    .b_in      (b_in),
    .out_valid (out_valid),
    .x_out     (x_out),
    .x_rd_addr (x_rd_addr),
    .x_rd_data (x_rd_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef GSIM_HOST_RESID_EN
    ,
    .max_resid (max_resid),
    .pass      (pass)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: buffer contents and what every output must show now.
  logic signed [15:0] b_model [N];
  logic signed [31:0] x_model [N];
  logic signed [31:0] xin [N];
  logic               exp_in_en, exp_busy, exp_done;
  logic signed [15:0] exp_b_in;
  logic [1:0]         exp_err;
  longint             exp_mr;
  logic               exp_pass;
  logic               cmp_en = 1'b0;
  int                 vectors = 0;
  int                 miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_en", in_en, exp_in_en);
      check("b_in", b_in, exp_b_in);
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("err", err, exp_err);
      check("x_rd_data", x_rd_data, x_model[x_rd_addr]);
`ifdef GSIM_HOST_RESID_EN
      if (exp_done) begin
        check("max_resid", max_resid, exp_mr);
        check("pass", pass, exp_pass);
      end
`endif
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic set_idle();
    exp_in_en = 1'b0; exp_b_in = '0; exp_busy = 1'b0; exp_done = 1'b0;
  endtask

  task automatic set_busy();
    exp_in_en = 1'b0; exp_b_in = '0; exp_busy = 1'b1; exp_done = 1'b0;
  endtask

  task automatic zero_model();
    for (int i = 0; i < N; i++) begin
      b_model[i] = '0;
      x_model[i] = '0;
    end
    exp_err  = 2'd0;
    exp_mr   = 0;
    exp_pass = 1'b0;
  endtask

  // Advance one clock; a host b write issued this cycle lands in the model.
  task automatic step();
    @(posedge clk);
    #1;
    if (b_wr && reset) b_model[b_wr_addr] = b_wr_data;
    b_wr      = 1'b0;
    x_rd_addr = 4'($urandom_range(0, N - 1));
  endtask

  task automatic rand_bwr();
    if ($urandom_range(0, 3) == 0) begin
      b_wr      = 1'b1;
      b_wr_addr = 4'($urandom_range(0, N - 1));
      b_wr_data = 16'($urandom);
    end
  endtask

`ifdef GSIM_HOST_RESID_EN
  function automatic longint resid_max();
    int     c [7] = '{-1, 6, -13, 20, -13, 6, -1};
    longint best = 0;
    longint r;
    for (int i = 0; i < N; i++) begin
      r = -(longint'(b_model[i]) * 65536);
      for (int d = -3; d <= 3; d++)
        if (i + d >= 0 && i + d < N) r += longint'(c[d + 3]) * longint'(x_model[i + d]);
      if (r < 0) r = -r;
      if (r > best) best = r;
    end
    return best;
  endfunction
`endif

  task automatic load_b(input bit ramp);
    for (int k = 0; k < N; k++) begin
      b_wr      = 1'b1;
      b_wr_addr = 4'(k);
      b_wr_data = ramp ? 16'(k) : 16'($urandom);
      set_idle();
      step();
    end
    set_idle();
  endtask

  task automatic load_b_zero();
    for (int k = 0; k < N; k++) begin
      b_wr = 1'b1; b_wr_addr = 4'(k); b_wr_data = '0;
      set_idle();
      step();
    end
    set_idle();
  endtask

  // One complete run; the current cycle must be IDLE. tmo: responder stays silent.
  task automatic run(input int delay, input int nwords, input bit tmo);
    int cnt;
    start = 1'b1;
    step();
    start    = 1'b0;
    exp_err  = 2'd0;
    exp_mr   = 0;
    exp_pass = 1'b0;
    for (int k = 0; k < N; k++) begin
      set_busy();
      exp_in_en = 1'b1;
      exp_b_in  = b_model[k];
      out_valid = 1'($urandom_range(0, 1));
      start     = 1'($urandom_range(0, 1));
      rand_bwr();
      step();
    end
    out_valid = 1'b0;
    start     = 1'b0;
    set_busy();
    if (tmo) begin
      cnt = 0;
      while (!done && cnt < TIMEOUT + 8) begin
        start = 1'($urandom_range(0, 1));
        rand_bwr();
        step();
        cnt++;
        set_busy();
        if (cnt == TIMEOUT) begin
          exp_done = 1'b1;
          exp_err  = 2'd1;
        end
      end
      start = 1'b0;
      check("timeout_cycles", cnt, TIMEOUT);
      check("timeout_err", err, 2'd1);
    end else begin
      for (int w = 0; w < delay; w++) begin
        rand_bwr();
        step();
      end
      for (int k = 0; k < nwords; k++) begin
        out_valid = 1'b1;
        x_out     = xin[k];
        step();
        x_model[k] = xin[k];
        set_busy();
      end
      out_valid = 1'b0;
      x_out     = 32'($urandom);
      if (nwords < N) begin
        step();
        exp_err = 2'd2;
        check("short_err", err, 2'd2);
      end else begin
`ifdef GSIM_HOST_RESID_EN
        for (int r = 0; r < N; r++) step();
        exp_mr   = resid_max();
        exp_pass = (exp_mr <= 64) && (exp_err == 2'd0);
`endif
      end
      set_busy();
      exp_done = 1'b1;
    end
    step();
    set_idle();
  endtask

  initial begin
    zero_model();
    set_idle();
    #2;
    cmp_en = 1'b1;
    step();
    check("reset_busy", busy, 1'b0);
    check("reset_err", err, 2'd0);
    reset = 1'b1;
    step();

    // Ramp b and the k<<16 response burst.
    load_b(1'b1);
    for (int k = 0; k < N; k++) xin[k] = 32'h0001_0000 * k;
    run(3, N, 1'b0);
    check("run1_err", err, 2'd0);
    for (int i = 0; i < N; i += 5) begin
      step();
      x_rd_addr = 4'(i);
      #1;
      check("run1_x_lit", x_rd_data, 32'h0001_0000 * i);
    end

    run(0, 0, 1'b1);

    for (int k = 0; k < N; k++) xin[k] = 32'($urandom);
    run(1, 10, 1'b0);
    step();
    x_rd_addr = 4'd12;
    #1;
    check("short_x12_kept", x_rd_data, 32'h000C_0000);

    // Reset while in SEND cycle 7.
    load_b(1'b0);
    start = 1'b1;
    step();
    start   = 1'b0;
    exp_err = 2'd0;
    for (int k = 0; k < 7; k++) begin
      set_busy(); exp_in_en = 1'b1; exp_b_in = b_model[k];
      rand_bwr();
      step();
    end
    set_busy(); exp_in_en = 1'b1; exp_b_in = b_model[7];
    #2;
    reset = 1'b0;
    zero_model();
    set_idle();
    #1;
    check("rst_mid_in_en", in_en, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    step();
    step();
    reset = 1'b1;
    step();
    load_b(1'b0);
    for (int k = 0; k < N; k++) xin[k] = 32'($urandom);
    run(2, N, 1'b0);
    check("post_rst_err", err, 2'd0);

`ifdef GSIM_HOST_RESID_EN
    load_b_zero();
    for (int k = 0; k < N; k++) xin[k] = '0;
    run(0, N, 1'b0);
    check("resid_zero_max", max_resid, 38'd0);
    check("resid_zero_pass", pass, 1'b1);
    xin[0] = 32'h0001_0000;
    run(1, N, 1'b0);
    check("resid_x0_max", max_resid, 38'd20 << 16);
    check("resid_x0_pass", pass, 1'b0);
`endif

    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 1) load_b(1'b0);
      for (int k = 0; k < N; k++)
        xin[k] = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($signed(16'($urandom)));
      run($urandom_range(0, 5), ($urandom_range(0, 2) == 0) ? $urandom_range(1, N - 1) : N, 1'b0);
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
